stt_train_ctrl: RTL and testbench

- Sequences the station-name display by generating the one-hot `total_loc` / `section_loc` position codes consumed by `stt_name`.
- Models a single train shuttling over 6 stations (index 0..5), with 4 sections per inter-station segment.
- Handles door dwell, departure, travel timing and direction reversal at both terminals.
- Sits between the board clock/buttons and the name decoder / LCD writer; `lcd_upd` tells the LCD writer to refresh.

---
 rtl/stt_train_ctrl_if.sv | 21 ++
 rtl/stt_train_ctrl.sv | 107 ++++++++++
 tb/tb_stt_train_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/stt_train_ctrl_if.sv
// rtl/stt_train_ctrl_if.sv - control inputs and position/status outputs of the train sequencer
interface stt_train_ctrl_if;
  logic       run;
  logic       depart_req;
  logic [5:0] total_loc;
  logic [3:0] section_loc;
  logic       dir;
  logic       door_open;
  logic       moving;
  logic       lcd_upd;

  modport master (
    output run, depart_req,
    input  total_loc, section_loc, dir, door_open, moving, lcd_upd
  );

  modport slave (
    input  run, depart_req,
    output total_loc, section_loc, dir, door_open, moving, lcd_upd
  );
endinterface

// File: rtl/stt_train_ctrl.sv
// rtl/stt_train_ctrl.sv - shuttle train sequencer producing one-hot station/section codes
module stt_train_ctrl #(
  parameter int TICK_DIV      = 50_000_000,
  parameter int DWELL_TICKS   = 5,
  parameter int SECTION_TICKS = 2
) (
  input logic             clk,
  input logic             rst_n,
  stt_train_ctrl_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DWELL_TICKS + 1);
  localparam int SW = $clog2(SECTION_TICKS + 1);
  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
  localparam logic [SW-1:0] SECT_LAST  = SW'(SECTION_TICKS - 1);
  localparam logic [4:0]    POS_END    = 5'd20;

  typedef enum logic [1:0] {DWELL, CLOSE, RUN} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pre_cnt;
  logic [DW-1:0] dwell_cnt, dwell_nxt;
  logic [SW-1:0] sect_cnt, sect_nxt;
  logic [4:0]    pos, pos_nxt, pos_adj;
  logic          dir_nxt, step, first_frame, tick;

  assign tick    = bus.run && (pre_cnt == PRE_LAST);
  assign pos_adj = bus.dir ? pos - 5'd1 : pos + 5'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= DWELL;
      pre_cnt         <= '0;
      dwell_cnt       <= '0;
      sect_cnt        <= '0;
      pos             <= '0;
      first_frame     <= 1'b1;
      bus.total_loc   <= 6'b000001;
      bus.section_loc <= 4'b0001;
      bus.dir         <= 1'b0;
      bus.door_open   <= 1'b1;
      bus.moving      <= 1'b0;
      bus.lcd_upd     <= 1'b0;
    end else begin
      if (bus.run) begin
        pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      end
      state       <= state_nxt;
      dwell_cnt   <= dwell_nxt;
      sect_cnt    <= sect_nxt;
      pos         <= pos_nxt;
      first_frame <= 1'b0;
      // Outputs follow the next-state values so they change in the same cycle as the state.
      bus.total_loc   <= 6'b000001 << pos_nxt[4:2];
      bus.section_loc <= 4'b0001 << pos_nxt[1:0];
      bus.dir         <= dir_nxt;
      bus.door_open   <= (state_nxt == DWELL);
      bus.moving      <= (state_nxt == RUN);
      bus.lcd_upd     <= step | first_frame;
    end
  end

  always_comb begin
    state_nxt = state;
    dwell_nxt = dwell_cnt;
    sect_nxt  = sect_cnt;
    pos_nxt   = pos;
    dir_nxt   = bus.dir;
    step      = 1'b0;
    if (bus.run) begin
      unique case (state)
        DWELL: begin
          if (bus.depart_req) begin
            state_nxt = CLOSE;
            dwell_nxt = '0;
          end else if (tick) begin
            if (dwell_cnt == DWELL_LAST) begin
              state_nxt = CLOSE;
              dwell_nxt = '0;
            end else begin
              dwell_nxt = dwell_cnt + 1'b1;
            end
          end
        end
        CLOSE: begin
          if (tick) state_nxt = RUN;
        end
        RUN: begin
          if (tick) begin
            if (sect_cnt == SECT_LAST) begin
              sect_nxt = '0;
              step     = 1'b1;
              pos_nxt  = pos_adj;
              if (pos_adj[1:0] == 2'd0) state_nxt = DWELL;
              // Reverse on terminal arrival so pos stays within 0..20.
              if (pos_adj == 5'd0 || pos_adj == POS_END) dir_nxt = ~bus.dir;
            end else begin
              sect_nxt = sect_cnt + 1'b1;
            end
          end
        end
        default: state_nxt = DWELL;
      endcase
    end
  end
endmodule

// File: tb/tb_stt_train_ctrl.sv
// tb/tb_stt_train_ctrl.sv - randomized and directed bench for stt_train_ctrl against a timeline model
module tb_stt_train_ctrl;
  localparam int TICK_DIV      = 4;
  localparam int DWELL_TICKS   = 3;
  localparam int SECTION_TICKS = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  stt_train_ctrl_if bus();

  stt_train_ctrl #(
    .TICK_DIV      (TICK_DIV),
    .DWELL_TICKS   (DWELL_TICKS),
    .SECTION_TICKS (SECTION_TICKS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [13:0] dut_vec;
  assign dut_vec = {bus.total_loc, bus.section_loc, bus.dir, bus.door_open, bus.moving, bus.lcd_upd};

  // Model: phase 0 doors open, 1 doors closed waiting, 2 travelling; m_left counts ticks remaining.
  int m_pos, m_dir, m_phase, m_left, m_runs;
  bit m_upd, m_first;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_dir = 0; m_phase = 0; m_left = DWELL_TICKS;
    m_runs = 0; m_upd = 1'b0; m_first = 1'b1;
  endtask

  task automatic model_step(input bit r, input bit d);
    bit t;
    m_upd   = m_first;
    m_first = 1'b0;
    if (r) begin
      m_runs++;
      t = (m_runs % TICK_DIV) == 0;
      if (m_phase == 0 && d) begin
        m_phase = 1; m_left = 1;
      end else if (t) begin
        m_left--;
        if (m_left == 0) begin
          if (m_phase == 0) begin
            m_phase = 1; m_left = 1;
          end else if (m_phase == 1) begin
            m_phase = 2; m_left = SECTION_TICKS;
          end else begin
            m_pos += (m_dir != 0) ? -1 : 1;
            m_upd = 1'b1;
            if (m_pos % 4 == 0) begin
              m_phase = 0; m_left = DWELL_TICKS;
            end else begin
              m_left = SECTION_TICKS;
            end
            if (m_pos == 0 || m_pos == 20) m_dir = 1 - m_dir;
          end
        end
      end
    end
  endtask

  function automatic logic [13:0] model_vec();
    logic [5:0] t;
    logic [3:0] s;
    t = 6'b000001 << (m_pos / 4);
    s = 4'b0001 << (m_pos % 4);
    return {t, s, (m_dir != 0), (m_phase == 0), (m_phase == 2), m_upd};
  endfunction

  task automatic cycle(input bit r, input bit d);
    bus.run = r;
    bus.depart_req = d;
    @(posedge clk);
    model_step(r, d);
    cyc++;
    #1 check($sformatf("lockstep@%0d", cyc), 32'(dut_vec), 32'(model_vec()));
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.run = 1'b1;
    bus.depart_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_total_loc", 32'(bus.total_loc), 32'h01);
    check("rst_section_loc", 32'(bus.section_loc), 32'h1);
    check("rst_dir", 32'(bus.dir), 32'd0);
    check("rst_door_open", 32'(bus.door_open), 32'd1);
    check("rst_moving", 32'(bus.moving), 32'd0);
    check("rst_lcd_upd", 32'(bus.lcd_upd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc = 0;
  endtask

  initial begin
    bit seen20, seen19, seen0, found;

    // Initial frame and timed departure
    do_reset();
    for (int i = 0; i < 60; i++) begin
      cycle(1'b1, 1'b0);
      case (cyc)
        1: begin
          check("init_lcd_upd", 32'(bus.lcd_upd), 32'd1);
          check("init_total", 32'(bus.total_loc), 32'h01);
          check("init_door", 32'(bus.door_open), 32'd1);
        end
        2:  check("init_lcd_once", 32'(bus.lcd_upd), 32'd0);
        11: check("dwell_11_open", 32'(bus.door_open), 32'd1);
        12: check("close_12", 32'(bus.door_open), 32'd0);
        15: check("still_close_15", 32'(bus.moving), 32'd0);
        16: check("run_16", 32'(bus.moving), 32'd1);
        23: check("sect_23", 32'(bus.section_loc), 32'h1);
        24: begin
          check("sect_24", 32'(bus.section_loc), 32'h2);
          check("lcd_24", 32'(bus.lcd_upd), 32'd1);
        end
        48: begin
          check("total_48", 32'(bus.total_loc), 32'h02);
          check("sect_48", 32'(bus.section_loc), 32'h1);
          check("door_48", 32'(bus.door_open), 32'd1);
        end
        default: ;
      endcase
    end

    // Early departure, then a depart_req during RUN
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, (i == 5) || (i == 10));
      if (cyc == 5)  check("early_close", 32'(bus.door_open), 32'd0);
      if (cyc == 8)  check("early_run", 32'(bus.moving), 32'd1);
      if (cyc == 15) check("early_sect15", 32'(bus.section_loc), 32'h1);
      if (cyc == 16) check("early_sect16", 32'(bus.section_loc), 32'h2);
    end

    // depart_req coincident with a tick
    do_reset();
    for (int i = 1; i <= 14; i++) begin
      cycle(1'b1, i == 8);
      if (cyc == 8)  check("coinc_close", 32'(bus.door_open), 32'd0);
      if (cyc == 11) check("coinc_wait", 32'(bus.moving), 32'd0);
      if (cyc == 12) check("coinc_run", 32'(bus.moving), 32'd1);
    end

    // Full shuttle: out to terminal 5 and back to terminal 0
    do_reset();
    seen20 = 0; seen19 = 0; seen0 = 0;
    for (int i = 0; i < 800 && !seen0; i++) begin
      cycle(1'b1, 1'b0);
      if (m_upd && m_pos == 20 && !seen20) begin
        seen20 = 1;
        check("term20_total", 32'(bus.total_loc), 32'h20);
        check("term20_sect", 32'(bus.section_loc), 32'h1);
        check("term20_dir", 32'(bus.dir), 32'd1);
      end else if (m_upd && seen20 && !seen19 && m_pos == 19) begin
        seen19 = 1;
        check("rev19_total", 32'(bus.total_loc), 32'h10);
        check("rev19_sect", 32'(bus.section_loc), 32'h8);
      end else if (m_upd && seen19 && m_pos == 0) begin
        seen0 = 1;
        check("term0_total", 32'(bus.total_loc), 32'h01);
        check("term0_dir", 32'(bus.dir), 32'd0);
      end
    end
    check("shuttle_done", 32'(seen0), 32'd1);

    // Random run/depart traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0);
    end

    // Freeze mid-RUN for 37 cycles
    do_reset();
    for (int i = 0; i < 26; i++) cycle(1'b1, 1'b0);
    for (int i = 0; i < 37; i++) cycle(1'b0, (i % 5) == 0);
    check("frz_sect", 32'(bus.section_loc), 32'h2);
    check("frz_moving", 32'(bus.moving), 32'd1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
    check("resume_hold", 32'(bus.section_loc), 32'h2);
    cycle(1'b1, 1'b0);
    check("resume_step", 32'(bus.section_loc), 32'h4);
    check("resume_lcd", 32'(bus.lcd_upd), 32'd1);

    // Async reset while travelling at pos 9
    do_reset();
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      cycle(1'b1, 1'b0);
      if (m_pos == 9) found = 1;
    end
    check("reach_pos9", 32'(found), 32'd1);
    check("pos9_total", 32'(bus.total_loc), 32'h04);
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
